multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM control unit for the multi-cycle RV32I core (one unified instr/data memory, shared ALU).
//  Successor to the single-cycle controller: sequences fetch/decode/execute over several cycles,
//  stalls for a parametrised memory latency, adds bne/blt/bge, jalr, lui and an illegal-opcode trap.
// PARAMETERS
//  MEM_LATENCY    3  cycles each memory access occupies (1..8); FETCH/MEMREAD/MEMWRITE dwell this long
//  EN_BRANCH_EXT  1  1: bne/blt/bge legal; 0: only beq legal, other funct3 under 1100011 -> ERROR
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  synchronous, active-high reset
//  op          in   7  instr[6:0] from IR;  funct3 in 3 instr[14:12];  funct7b5 in 1 instr[30]
//  zero        in   1  ALU result == 0 (BRANCH state);  lt in 1 signed rs1<rs2 (BRANCH state)
//  pc_write    out  1  load PC from result bus;  adr_src out 1: 0=PC, 1=result bus
//  ir_write    out  1  load IR and oldPC;  mem_write out 1 memory write strobe
//  reg_write   out  1  register file write;  result_src out 2: 00 ALUOut, 01 Data, 10 ALUResult
//  alu_src_a   out  2  00 PC, 01 oldPC, 10 rs1;  alu_src_b out 2: 00 rs2, 01 imm, 10 const 4
//  alu_control out  3  000 add,001 sub,010 and,011 or,100 xor,101 slt,111 pass-B
//  imm_src     out  3  000 I, 001 S, 010 B, 011 J, 100 U
//  illegal     out  1  high while in ERROR;  instr_done out 1 one-cycle pulse on an instruction's last cycle
// BEHAVIOUR
//  - Reset: state<=FETCH, wait counter<=0; while rst high all write enables, illegal, instr_done are 0.
//  - Outputs are combinational from state (+ wait count, funct, flags); unlisted outputs = 0/00.
//  - Wait counter: in FETCH/MEMREAD/MEMWRITE counts 0..MEM_LATENCY-1; "last" = count==MEM_LATENCY-1;
//    state advances only on last; counter clears on every state change.
//  - FETCH: adr_src0, a=00, b=10, add, result_src 10; ir_write+pc_write on last only -> DECODE.
//  - DECODE: a=01, b=01, add (branch/jal target into ALUOut); imm_src from op. Next by op:
//    0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH (or ERROR per
//    EN_BRANCH_EXT / funct3 not in {000,001,100,101}), 1101111->JAL, 1100111->JALR, 0110111->LUI, else ERROR.
//  - MEMADR: a=10,b=01,add; imm I(lw)/S(sw) -> MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: adr_src1, result_src00 -> MEMWB on last. MEMWB: result_src01, reg_write -> FETCH.
//  - MEMWRITE: adr_src1, result_src00, mem_write on last cycle only -> FETCH.
//  - EXEC_R: a=10,b=00; EXEC_I: a=10,b=01,imm I; both -> ALU_WB. ALU decode: funct3 000 add
//    (sub iff R-type & funct7b5), 100 xor, 110 or, 111 and, 010 slt; other funct3 -> ERROR from DECODE.
//  - ALU_WB: result_src00, reg_write -> FETCH.
//  - BRANCH: a=10,b=00,sub, result_src00; pc_write = taken: beq zero, bne !zero, blt lt, bge !lt -> FETCH.
//  - JAL: a=01,b=10,add, result_src00, pc_write -> ALU_WB (links oldPC+4).
//  - JALR: a=10,b=01,add, imm I, result_src10, pc_write -> LINK; LINK: a=01,b=10,add, result_src10,
//    reg_write -> FETCH.  LUI: b=01, imm U, pass-B, result_src10, reg_write -> FETCH.
//  - ERROR: sticky until rst; no enables; illegal=1.
//  - instr_done on last cycle of MEMWB, MEMWRITE, ALU_WB, BRANCH, LINK, LUI.
//  - Latency (L=MEM_LATENCY): R/I/jal L+3, lw 2L+3, sw 2L+2, branch/lui L+2, jalr L+3 cycles.
//  - Reset mid-wait: counter and state restart at FETCH next cycle; no partial write survives.
// STRUCTURE
//  - multicycle_pkg: state enum, opcode constants, alu_control/imm_src/result_src/src_a/src_b encodings.
//  - Sub-module alu_decoder (combinational op/funct3/funct7b5 -> alu_control, legal flag).
//  - Top: state reg + $clog2(MEM_LATENCY)-bit wait counter (min 1 bit) + output decode.
// TESTING
//  - L=3, add x3,x1,x2: FETCH x3, DECODE, EXEC_R, ALU_WB; ir_write only cycle 3; reg_write cycle 6; done cycle 6.
//  - L=3, lw then sw: lw states 9 cycles, reg_write+result_src01 at cycle 9; sw mem_write single pulse cycle 8.
//  - beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; blt lt=1 -> pc_write=1.
//  - EN_BRANCH_EXT=0, op 1100011 funct3 001 -> ERROR, illegal=1 held 10 cycles, released only by rst.
//  - jalr: JALR pc_write, result_src10, then LINK reg_write, a=01 b=10; op 1111111 -> ERROR.
//  - rst asserted in FETCH cycle 2 of 3 -> next cycle FETCH count 0, no ir_write/pc_write emitted.

Source files
------------

// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
//   Shared types and encodings for the multi-cycle RV32I control unit:
//   FSM state enum, major opcodes, branch funct3 codes and the encodings of
//   the datapath mux/ALU/immediate control fields.
// -----------------------------------------------------------------------------
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_ERROR
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_SLT    = 3'b101;
  localparam logic [2:0] ALU_PASS_B = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // beq is always implemented; bne/blt/bge only when the extension is enabled.
  function automatic logic branch_legal(input logic [2:0] f3, input logic ext);
    return (f3 == F3_BEQ) ||
           (ext && ((f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE)));
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Combinational ALU operation decode for R-type and I-type ALU instructions.
//   Ports:
//     op_i          instr[6:0]
//     funct3_i      instr[14:12]
//     funct7b5_i    instr[30]
//     alu_control_o ALU operation select
//     legal_o       funct3 names an implemented ALU operation
// -----------------------------------------------------------------------------
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       legal_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_control_o = ALU_ADD;
    legal_o       = 1'b1;
    case (funct3_i)
      // For addi, instr[30] is an immediate bit, so only R-type may subtract.
      3'b000:  alu_control_o = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b100:  alu_control_o = ALU_XOR;
      3'b110:  alu_control_o = ALU_OR;
      3'b111:  alu_control_o = ALU_AND;
      3'b010:  alu_control_o = ALU_SLT;
      default: legal_o       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Moore control FSM for the multi-cycle RV32I core (unified memory, shared
//   ALU). Memory states dwell MEM_LATENCY cycles; illegal opcodes trap into a
//   sticky ERROR state that only reset leaves.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     op, funct3, funct7b5      instruction fields from IR
//     zero, lt                  ALU flags used in BRANCH
//     pc_write, adr_src, ir_write, mem_write, reg_write   datapath enables/muxes
//     result_src, alu_src_a, alu_src_b, alu_control, imm_src   datapath selects
//     illegal                   high while trapped
//     instr_done                pulse on an instruction's final cycle
// -----------------------------------------------------------------------------
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int MEM_LATENCY   = 3,
  parameter bit EN_BRANCH_EXT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic       instr_done
);

  localparam int             CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LATENCY - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_wait, last, alu_legal, taken;
  logic [2:0]    alu_dec;

  alu_decoder u_alu_decoder (
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_dec),
    .legal_o       (alu_legal)
  );

  // Single-cycle states are always on their last cycle.
  assign mem_wait = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  assign last     = !mem_wait || (cnt_q == CNT_LAST);

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (last) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:      state_d = alu_legal ? S_EXEC_R : S_ERROR;
          OP_I:      state_d = alu_legal ? S_EXEC_I : S_ERROR;
          OP_BRANCH: state_d = branch_legal(funct3, EN_BRANCH_EXT) ? S_BRANCH : S_ERROR;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (last) state_d = S_MEMWB;
      S_MEMWRITE: if (last) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL: state_d = S_ALU_WB;
      S_JALR:     state_d = S_LINK;
      S_MEMWB, S_ALU_WB, S_BRANCH, S_LINK, S_LUI: state_d = S_FETCH;
      default:    state_d = S_ERROR;  // S_ERROR is sticky; unused encodings trap too
    endcase
    // A dwell state only ever leaves on its last count, so clearing whenever
    // the dwell is not continuing also clears on every state change.
    cnt_d = (mem_wait && !last) ? cnt_q + 1'b1 : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    illegal     = 1'b0;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = last;
        pc_write   = last;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_STORE:  imm_src = IMM_S;
          OP_BRANCH: imm_src = IMM_B;
          OP_JAL:    imm_src = IMM_J;
          OP_LUI:    imm_src = IMM_U;
          default:   imm_src = IMM_I;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = last;
        instr_done = last;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_control = alu_dec;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = alu_dec;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_control = ALU_SUB;
        pc_write    = taken;
        instr_done  = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
      end
      S_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_LUI: begin
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_U;
        alu_control = ALU_PASS_B;
        result_src  = RES_ALURESULT;
        reg_write   = 1'b1;
        instr_done  = 1'b1;
      end
      S_ERROR:  illegal = 1'b1;
      default:  illegal = 1'b1;
    endcase
    // The reset cycle must never commit architectural state.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Instruction-level model: each instruction is expanded into the per-cycle
//   control words it must produce, queued, and compared every cycle. Two
//   instances: L=3 with branch extension, L=2 without.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  localparam int L0 = 3;
  localparam int L1 = 2;
  localparam int E_PC = 1, E_IR = 2, E_MW = 4, E_RW = 8, E_ILL = 16, E_DONE = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0;
  bit         sel = 1'b0;

  logic       d0_pc, d0_adr, d0_ir, d0_mw, d0_rw, d0_ill, d0_done;
  logic [1:0] d0_rs, d0_a, d0_b;
  logic [2:0] d0_alu, d0_imm;
  logic       d1_pc, d1_adr, d1_ir, d1_mw, d1_rw, d1_ill, d1_done;
  logic [1:0] d1_rs, d1_a, d1_b;
  logic [2:0] d1_alu, d1_imm;
  ctrl_t      act0, act1;

  assign act0 = {d0_pc, d0_adr, d0_ir, d0_mw, d0_rw, d0_rs, d0_a, d0_b, d0_alu, d0_imm, d0_ill, d0_done};
  assign act1 = {d1_pc, d1_adr, d1_ir, d1_mw, d1_rw, d1_rs, d1_a, d1_b, d1_alu, d1_imm, d1_ill, d1_done};

  multicycle_controller #(.MEM_LATENCY(L0), .EN_BRANCH_EXT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero), .lt(lt),
    .pc_write(d0_pc), .adr_src(d0_adr), .ir_write(d0_ir), .mem_write(d0_mw), .reg_write(d0_rw),
    .result_src(d0_rs), .alu_src_a(d0_a), .alu_src_b(d0_b), .alu_control(d0_alu),
    .imm_src(d0_imm), .illegal(d0_ill), .instr_done(d0_done));

  multicycle_controller #(.MEM_LATENCY(L1), .EN_BRANCH_EXT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero), .lt(lt),
    .pc_write(d1_pc), .adr_src(d1_adr), .ir_write(d1_ir), .mem_write(d1_mw), .reg_write(d1_rw),
    .result_src(d1_rs), .alu_src_a(d1_a), .alu_src_b(d1_b), .alu_control(d1_alu),
    .imm_src(d1_imm), .illegal(d1_ill), .instr_done(d1_done));

  always #5 clk = ~clk;

  ctrl_t q[$];
  string cur_name = "reset";
  int    vectors = 0, miscompares = 0;
  int    obs_cyc, obs_ir, obs_rw, obs_rs, obs_mw, obs_mw_cyc, obs_pc, obs_done, obs_ill;

  function automatic ctrl_t mk(input int a, input int b, input int alu, input int imm,
                               input int rs, input int adr, input int en);
    mk             = '0;
    mk.alu_src_a   = 2'(a);
    mk.alu_src_b   = 2'(b);
    mk.alu_control = 3'(alu);
    mk.imm_src     = 3'(imm);
    mk.result_src  = 2'(rs);
    mk.adr_src     = 1'(adr);
    mk.pc_write    = en[0];
    mk.ir_write    = en[1];
    mk.mem_write   = en[2];
    mk.reg_write   = en[3];
    mk.illegal     = en[4];
    mk.instr_done  = en[5];
  endfunction

  // Instruction-set view of the ALU: -1 marks an unimplemented funct3.
  function automatic int alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o == 7'b0110011 && f7) ? 1 : 0;
      3'd4:    return 4;
      3'd6:    return 3;
      3'd7:    return 2;
      3'd2:    return 5;
      default: return -1;
    endcase
  endfunction

  task automatic push_n(input ctrl_t w, input int n);
    for (int i = 0; i < n; i++) q.push_back(w);
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Expands one instruction into its cycle-by-cycle control words.
  task automatic model_instr(input int L, input bit ext, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic l, input int err_n);
    int  imm, alu;
    bit  tk, bok;
    for (int i = 0; i < L; i++) q.push_back(mk(0, 2, 0, 0, 2, 0, (i == L - 1) ? (E_PC | E_IR) : 0));
    case (o)
      7'b0100011: imm = 1;
      7'b1100011: imm = 2;
      7'b1101111: imm = 3;
      7'b0110111: imm = 4;
      default:    imm = 0;
    endcase
    q.push_back(mk(1, 1, 0, imm, 0, 0, 0));
    alu = alu_of(o, f3, f7);
    bok = (f3 == 3'd0) || (ext && (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5));
    tk  = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? l : !l;
    case (o)
      7'b0000011: begin
        q.push_back(mk(2, 1, 0, 0, 0, 0, 0));
        push_n(mk(0, 0, 0, 0, 0, 1, 0), L);
        q.push_back(mk(0, 0, 0, 0, 1, 0, E_RW | E_DONE));
      end
      7'b0100011: begin
        q.push_back(mk(2, 1, 0, 1, 0, 0, 0));
        push_n(mk(0, 0, 0, 0, 0, 1, 0), L - 1);
        q.push_back(mk(0, 0, 0, 0, 0, 1, E_MW | E_DONE));
      end
      7'b0110011, 7'b0010011: begin
        if (alu < 0) push_n(mk(0, 0, 0, 0, 0, 0, E_ILL), err_n);
        else begin
          q.push_back(mk(2, (o == 7'b0010011) ? 1 : 0, alu, 0, 0, 0, 0));
          q.push_back(mk(0, 0, 0, 0, 0, 0, E_RW | E_DONE));
        end
      end
      7'b1100011: begin
        if (!bok) push_n(mk(0, 0, 0, 0, 0, 0, E_ILL), err_n);
        else q.push_back(mk(2, 0, 1, 0, 0, 0, E_DONE | (tk ? E_PC : 0)));
      end
      7'b1101111: begin
        q.push_back(mk(1, 2, 0, 0, 0, 0, E_PC));
        q.push_back(mk(0, 0, 0, 0, 0, 0, E_RW | E_DONE));
      end
      7'b1100111: begin
        q.push_back(mk(2, 1, 0, 0, 2, 0, E_PC));
        q.push_back(mk(1, 2, 0, 0, 2, 0, E_RW | E_DONE));
      end
      7'b0110111: q.push_back(mk(0, 1, 7, 4, 2, 0, E_RW | E_DONE));
      default:    push_n(mk(0, 0, 0, 0, 0, 0, E_ILL), err_n);
    endcase
  endtask

  // Single compare process: one queued expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      ctrl_t e, a;
      e = q.pop_front();
      a = sel ? act1 : act0;
      obs_cyc++;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b want %b", cur_name, obs_cyc, a, e);
      end
      if (a.ir_write === 1'b1 && obs_ir == 0) obs_ir = obs_cyc;
      if (a.reg_write === 1'b1) begin obs_rw = obs_cyc; obs_rs = int'(a.result_src); end
      if (a.mem_write === 1'b1) begin obs_mw++; obs_mw_cyc = obs_cyc; end
      if (a.pc_write === 1'b1) obs_pc++;
      if (a.instr_done === 1'b1) obs_done = obs_cyc;
      if (a.illegal === 1'b1) obs_ill++;
    end
  end

  task automatic clear_obs(input string name);
    cur_name = name;
    obs_cyc = 0; obs_ir = 0; obs_rw = 0; obs_rs = 0; obs_mw = 0;
    obs_mw_cyc = 0; obs_pc = 0; obs_done = 0; obs_ill = 0;
  endtask

  // Returns just after a rising edge once every queued word has been compared.
  task automatic drain();
    int guard = 0;
    while (q.size() != 0) begin
      @(posedge clk);
      guard++;
      if (guard > 200) begin
        check({cur_name, "_timeout"}, q.size(), 0);
        q.delete();
      end
    end
    #1;
  endtask

  // first: expected word during the cycle rst rises (current state, enables gated).
  task automatic do_reset(input ctrl_t first);
    clear_obs("reset");
    rst = 1'b1;
    q.push_back(first);
    q.push_back(mk(0, 2, 0, 0, 2, 0, 0));
    drain();
    rst = 1'b0;
  endtask

  task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic l, input int err_n);
    clear_obs(name);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l;
    model_instr(sel ? L1 : L0, !sel, o, f3, f7, z, l, err_n);
    drain();
  endtask

  initial begin
    ctrl_t fidle;
    fidle = mk(0, 2, 0, 0, 2, 0, 0);
    @(posedge clk); #1;
    do_reset(fidle);

    run("add", 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    check("add_ir_cycle", obs_ir, 3);
    check("add_rw_cycle", obs_rw, 6);
    check("add_done_cycle", obs_done, 6);
    run("sub", 7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 0);
    run("addi_b30", 7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 0);
    run("xori", 7'b0010011, 3'd4, 1'b0, 1'b0, 1'b0, 0);
    run("or", 7'b0110011, 3'd6, 1'b0, 1'b0, 1'b0, 0);
    run("and", 7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, 0);
    run("slt", 7'b0110011, 3'd2, 1'b0, 1'b0, 1'b0, 0);
    run("lw", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0);
    check("lw_len", obs_cyc, 9);
    check("lw_rw_cycle", obs_rw, 9);
    check("lw_rw_src", obs_rs, 1);
    run("sw", 7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0);
    check("sw_len", obs_cyc, 8);
    check("sw_mw_count", obs_mw, 1);
    check("sw_mw_cycle", obs_mw_cyc, 8);
    run("beq_z1", 7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 0);
    check("beq_pc_writes", obs_pc, 2);
    run("bne_z1", 7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 0);
    check("bne_pc_writes", obs_pc, 1);
    run("blt_lt1", 7'b1100011, 3'd4, 1'b0, 1'b0, 1'b1, 0);
    check("blt_pc_writes", obs_pc, 2);
    run("bge_lt1", 7'b1100011, 3'd5, 1'b0, 1'b0, 1'b1, 0);
    run("bne_z0", 7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 0);
    run("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    run("jalr", 7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    check("jalr_len", obs_cyc, 6);
    run("lui", 7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    check("lui_len", obs_cyc, 5);

    run("r_f3_001", 7'b0110011, 3'd1, 1'b0, 1'b0, 1'b0, 3);
    do_reset(mk(0, 0, 0, 0, 0, 0, 0));
    run("op_7f", 7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 10);
    check("op_7f_illegal_cycles", obs_ill, 10);
    do_reset(mk(0, 0, 0, 0, 0, 0, 0));
    run("add_after_err", 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0);

    // Reset during FETCH cycle 2: dwell must restart from count 0.
    clear_obs("rst_fetch2");
    q.push_back(fidle);
    drain();
    rst = 1'b1;
    q.push_back(fidle);
    drain();
    rst = 1'b0;
    check("rst_fetch2_ir", obs_ir, 0);
    run("add_after_rst2", 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    check("rst2_ir_cycle", obs_ir, 3);

    // Reset during the last FETCH cycle: no ir_write/pc_write may escape.
    clear_obs("rst_fetch3");
    push_n(fidle, 2);
    drain();
    rst = 1'b1;
    q.push_back(fidle);
    drain();
    rst = 1'b0;
    check("rst_fetch3_pc", obs_pc, 0);
    run("add_after_rst3", 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0);

    // Second instance: L=2, beq only.
    rst = 1'b1;
    @(posedge clk); #1;
    sel = 1'b1;
    do_reset(fidle);
    run("n_beq_z1", 7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 0);
    check("n_beq_len", obs_cyc, 4);
    run("n_lw", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0);
    check("n_lw_len", obs_cyc, 7);
    run("n_bne", 7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 10);
    check("n_bne_illegal_cycles", obs_ill, 10);
    do_reset(mk(0, 0, 0, 0, 0, 0, 0));
    run("n_add", 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    check("n_add_len", obs_cyc, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
